// File: rtl/keyed_multi_pwm.sv
// keyed_multi_pwm: multi-channel PWM whose double-buffered duties are edited by single-cycle key pulses
module keyed_multi_pwm #(
    parameter int CLK_DIV  = 195,
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STEP     = 10,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [4:0]          key_pulse,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CH_W-1:0]     sel_ch,
    output logic [WIDTH-1:0]    sel_duty,
    output logic                period_start
);
    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH-1:0] HALF   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    logic [15:0]      pre;
    logic [WIDTH-1:0] seg;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] active [CHANNELS];
    logic             tick, wrap, edit_en;
    logic [WIDTH:0]   sum_step;
    logic [WIDTH-1:0] edit_val;
    assign tick     = pre == 16'(CLK_DIV);
    assign wrap     = tick && (&seg);
    assign sel_duty = shadow[sel_ch];
    assign edit_en  = |key_pulse[3:0];
    assign sum_step = {1'b0, sel_duty} + STEP_W;
    // Priority [0] > [1] > [2] > [3]; additions saturate rather than wrap.
    always_comb begin
        edit_val = key_pulse[0] ? ((sum_step > {1'b0, MAX}) ? MAX : sum_step[WIDTH-1:0]) :
                   key_pulse[1] ? (({1'b0, sel_duty} > STEP_W) ? sel_duty - STEP_W[WIDTH-1:0] : '0) :
                   key_pulse[2] ? ((sel_duty == MAX) ? MAX : sel_duty + 1'b1) :
                   HALF;
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre          <= '0;
            seg          <= '0;
            sel_ch       <= '0;
            period_start <= 1'b0;
            pwm_out      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            pre          <= tick ? '0 : pre + 16'd1;
            seg          <= tick ? seg + 1'b1 : seg;
            period_start <= wrap;
            if (key_pulse[4])
                sel_ch <= (sel_ch == CH_W'(CHANNELS-1)) ? '0 : sel_ch + 1'b1;
            // Active copies the pre-edit shadow; an edit on the boundary shows next period.
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= seg < active[i];
                if (wrap)
                    active[i] <= shadow[i];
                if (edit_en && sel_ch == CH_W'(i))
                    shadow[i] <= edit_val;
            end
        end
    end
endmodule

// File: tb/tb_keyed_multi_pwm.sv
// tb_keyed_multi_pwm: directed table, period measurements and random keys against an arithmetic model
module tb_keyed_multi_pwm;
    localparam int CLK_DIV = 3, WIDTH = 4, CHANNELS = 2, STEP = 3;
    localparam int MAXD = 2**WIDTH - 1, SEGS = 2**WIDTH, PER = SEGS * (CLK_DIV + 1);

    logic       CLK = 0, RSTn = 0;
    logic [4:0] key_pulse = '0;
    logic [1:0] pwm_out;
    logic       sel_ch;
    logic [3:0] sel_duty;
    logic       period_start;

    keyed_multi_pwm #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH), .CHANNELS(CHANNELS), .STEP(STEP)) dut (
        .CLK(CLK), .RSTn(RSTn), .key_pulse(key_pulse), .pwm_out(pwm_out),
        .sel_ch(sel_ch), .sel_duty(sel_duty), .period_start(period_start)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    int c, m_sel;
    int m_sh [CHANNELS];
    int m_act [CHANNELS];
    logic [1:0] e_pwm;
    bit e_ps;

    typedef struct { logic [4:0] k; int sel; int duty; } vec_t;
    vec_t tbl [17];

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        c = 0; m_sel = 0; e_pwm = '0; e_ps = 0;
        for (int i = 0; i < CHANNELS; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    endtask

    // c = clock edges since reset release; segment and boundary follow by arithmetic.
    task automatic model_edge(input logic [4:0] k);
        int seg, s;
        seg = (c / (CLK_DIV + 1)) % SEGS;
        for (int i = 0; i < CHANNELS; i++) e_pwm[i] = seg < m_act[i];
        e_ps = (c % PER) == PER - 1;
        if (e_ps) for (int i = 0; i < CHANNELS; i++) m_act[i] = m_sh[i];
        s = m_sh[m_sel];
        if (k[0]) s = (s + STEP > MAXD) ? MAXD : s + STEP;
        else if (k[1]) s = (s > STEP) ? s - STEP : 0;
        else if (k[2]) s = (s + 1 > MAXD) ? MAXD : s + 1;
        else if (k[3]) s = 2**(WIDTH-1) - 1;
        m_sh[m_sel] = s;
        if (k[4]) m_sel = (m_sel + 1) % CHANNELS;
        c++;
    endtask

    task automatic step(input logic [4:0] k);
        key_pulse = k;
        @(posedge CLK);
        model_edge(k);
        #1;
        key_pulse = '0;
        chk("pwm_out", pwm_out, e_pwm);
        chk("period_start", period_start, e_ps);
        chk("sel_ch", sel_ch, m_sel);
        chk("sel_duty", sel_duty, m_sh[m_sel]);
    endtask

    task automatic wait_ps();
        int n = 0;
        while (period_start !== 1'b1 && n < 2 * PER) begin step(0); n++; end
        chk("period_start_seen", period_start, 1);
    endtask

    // Counts high cycles of channel ch over one period; keys kidx..kidx+1 get key[0].
    task automatic count_period(input int ch, input int kidx, output int hi);
        hi = 0;
        for (int j = 0; j < PER; j++) begin
            step((j == kidx || j == kidx + 1) ? 5'b00001 : 5'b00000);
            hi += int'(pwm_out[ch]);
        end
    endtask

    task automatic do_reset();
        #3 RSTn = 0;
        #1;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_sel", sel_ch, 0);
        chk("rst_duty", sel_duty, 0);
        model_reset();
        @(negedge CLK);
        RSTn = 1;
    endtask

    initial begin
        int hi, hi1, gap;
        tbl[0]  = '{5'b00001, 0, 3};   tbl[1]  = '{5'b00001, 0, 6};
        tbl[2]  = '{5'b00100, 0, 7};   tbl[3]  = '{5'b00010, 0, 4};
        tbl[4]  = '{5'b01000, 0, 7};   tbl[5]  = '{5'b00011, 0, 10};
        tbl[6]  = '{5'b10010, 1, 0};   tbl[7]  = '{5'b00010, 1, 0};
        tbl[8]  = '{5'b00100, 1, 1};   tbl[9]  = '{5'b00001, 1, 4};
        tbl[10] = '{5'b10000, 0, 7};   tbl[11] = '{5'b01100, 0, 8};
        tbl[12] = '{5'b00001, 0, 11};  tbl[13] = '{5'b00001, 0, 14};
        tbl[14] = '{5'b00001, 0, 15};  tbl[15] = '{5'b00100, 0, 15};
        tbl[16] = '{5'b00010, 0, 12};

        model_reset();
        #12;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_sel", sel_ch, 0);
        chk("rst_duty", sel_duty, 0);
        @(negedge CLK);
        RSTn = 1;

        // Idle: outputs low, period_start every PER clocks.
        wait_ps();
        for (int p = 0; p < 2; p++) begin
            gap = 0;
            do begin step(0); gap++; end while (period_start !== 1'b1 && gap < 2 * PER);
            chk("period_gap", gap, PER);
        end

        // Duty 6 -> 24 of 64.
        step(5'b00001); step(5'b00001);
        chk("duty6", sel_duty, 6);
        wait_ps();
        count_period(0, -5, hi);
        chk("ch0_hi_24", hi, 24);
        count_period(1, -5, hi1);
        chk("ch1_hi_0", hi1, 0);

        // Saturation up and down.
        repeat (6) step(5'b00001);
        chk("duty_sat_hi", sel_duty, 15);
        wait_ps();
        count_period(0, -5, hi);
        chk("ch0_hi_60", hi, 60);
        repeat (6) step(5'b00010);
        chk("duty_sat_lo", sel_duty, 0);
        wait_ps();
        count_period(0, -5, hi);
        chk("ch0_hi_0", hi, 0);

        // Channel select and half.
        step(5'b10000);
        chk("sel_1", sel_ch, 1);
        step(5'b01000);
        chk("ch1_half", sel_duty, 7);
        step(5'b10000);
        chk("sel_wrap", sel_ch, 0);
        chk("ch0_unchanged", sel_duty, 0);

        // Mid-period edit only shows from the next period.
        step(5'b00001); step(5'b00001);
        wait_ps();
        count_period(0, 10, hi);
        chk("mid_edit_old", hi, 24);
        chk("mid_edit_shadow", sel_duty, 12);
        count_period(0, -5, hi);
        chk("mid_edit_new", hi, 48);

        // Async reset mid-pulse.
        begin
            int n = 0;
            while (pwm_out[0] !== 1'b1 && n < PER) begin step(0); n++; end
            chk("pulse_seen", pwm_out[0], 1);
        end
        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].k);
            chk("tbl_sel", sel_ch, tbl[i].sel);
            chk("tbl_duty", sel_duty, tbl[i].duty);
        end

        // Random keys, one reset in the middle.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            step(($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
